// File: rtl/new_wbck_pkg.sv
// Shared encodings for the write-back arbiter slice.
package new_wbck_pkg;

    typedef enum logic [1:0] {
        WBCK_SRC_NONE   = 2'd0,
        WBCK_SRC_ALU    = 2'd1,
        WBCK_SRC_LSU    = 2'd2,
        WBCK_SRC_MULDIV = 2'd3
    } wbck_src_e;

    localparam int WBCK_STARVE_LIM = 4;

endpackage

// File: rtl/new_wbck_starve_cnt.sv
// Saturating denial counter; starved once it reaches LIM.
module new_wbck_starve_cnt #(
    parameter int LIM = 4,
    parameter int W   = $clog2(LIM + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         starved
);

    localparam logic [W-1:0] LIM_V = W'(LIM);

    assign starved = (cnt == LIM_V);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !starved) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/new_wbck_arb.sv
// Write-back arbiter: picks one result per cycle for the regfile port.
module new_wbck_arb
    import new_wbck_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int RFIDX_W    = 5,
    parameter int STARVE_LIM = WBCK_STARVE_LIM
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               alu_wbck_vld,
    output logic               alu_wbck_rdy,
    input  logic               alu_wbck_wen,
    input  logic [RFIDX_W-1:0] alu_wbck_rdidx,
    input  logic [XLEN-1:0]    alu_wbck_wdat,
    input  logic               lsu_wbck_vld,
    output logic               lsu_wbck_rdy,
    input  logic               lsu_wbck_wen,
    input  logic [RFIDX_W-1:0] lsu_wbck_rdidx,
    input  logic [XLEN-1:0]    lsu_wbck_wdat,
    input  logic               muldiv_wbck_vld,
    output logic               muldiv_wbck_rdy,
    input  logic               muldiv_wbck_wen,
    input  logic [RFIDX_W-1:0] muldiv_wbck_rdidx,
    input  logic [XLEN-1:0]    muldiv_wbck_wdat,
    input  logic               halt_req,
    output logic               rf_wen,
    output logic [RFIDX_W-1:0] rf_rdidx,
    output logic [XLEN-1:0]    rf_wdat,
    output logic [1:0]         grant_src,
    output logic               wbck_idle
);

    localparam int CW = $clog2(STARVE_LIM + 1);

    logic          alu_st, lsu_st, md_st;
    logic [CW-1:0] alu_cnt, lsu_cnt, md_cnt;
    wbck_src_e     sel;

    new_wbck_starve_cnt #(.LIM(STARVE_LIM), .W(CW)) u_alu_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (!alu_wbck_vld || alu_wbck_rdy),
        .inc     (alu_wbck_vld && !alu_wbck_rdy && !halt_req),
        .cnt     (alu_cnt),
        .starved (alu_st)
    );

    new_wbck_starve_cnt #(.LIM(STARVE_LIM), .W(CW)) u_lsu_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (!lsu_wbck_vld || lsu_wbck_rdy),
        .inc     (lsu_wbck_vld && !lsu_wbck_rdy && !halt_req),
        .cnt     (lsu_cnt),
        .starved (lsu_st)
    );

    new_wbck_starve_cnt #(.LIM(STARVE_LIM), .W(CW)) u_md_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (!muldiv_wbck_vld || muldiv_wbck_rdy),
        .inc     (muldiv_wbck_vld && !muldiv_wbck_rdy && !halt_req),
        .cnt     (md_cnt),
        .starved (md_st)
    );

    // Starved requesters first (ALU > MULDIV > LSU), then LSU > MULDIV > ALU.
    always_comb begin
        sel = WBCK_SRC_NONE;
        if (halt_req)                         sel = WBCK_SRC_NONE;
        else if (alu_st && alu_wbck_vld)      sel = WBCK_SRC_ALU;
        else if (md_st && muldiv_wbck_vld)    sel = WBCK_SRC_MULDIV;
        else if (lsu_st && lsu_wbck_vld)      sel = WBCK_SRC_LSU;
        else if (lsu_wbck_vld)                sel = WBCK_SRC_LSU;
        else if (muldiv_wbck_vld)             sel = WBCK_SRC_MULDIV;
        else if (alu_wbck_vld)                sel = WBCK_SRC_ALU;
    end

    assign alu_wbck_rdy    = (sel == WBCK_SRC_ALU);
    assign lsu_wbck_rdy    = (sel == WBCK_SRC_LSU);
    assign muldiv_wbck_rdy = (sel == WBCK_SRC_MULDIV);

    logic               win_wen;
    logic [RFIDX_W-1:0] win_idx;
    logic [XLEN-1:0]    win_dat;

    always_comb begin
        win_wen = 1'b0;
        win_idx = '0;
        win_dat = '0;
        unique case (sel)
            WBCK_SRC_ALU: begin
                win_wen = alu_wbck_wen;
                win_idx = alu_wbck_rdidx;
                win_dat = alu_wbck_wdat;
            end
            WBCK_SRC_LSU: begin
                win_wen = lsu_wbck_wen;
                win_idx = lsu_wbck_rdidx;
                win_dat = lsu_wbck_wdat;
            end
            WBCK_SRC_MULDIV: begin
                win_wen = muldiv_wbck_wen;
                win_idx = muldiv_wbck_rdidx;
                win_dat = muldiv_wbck_wdat;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wen    <= 1'b0;
            rf_rdidx  <= '0;
            rf_wdat   <= '0;
            grant_src <= WBCK_SRC_NONE;
        end else if (sel != WBCK_SRC_NONE) begin
            // x0 writes still complete the handshake but never reach the regfile
            rf_wen    <= win_wen && (win_idx != '0);
            rf_rdidx  <= win_idx;
            rf_wdat   <= win_dat;
            grant_src <= sel;
        end else begin
            rf_wen    <= 1'b0;
        end
    end

    assign wbck_idle = !(alu_wbck_vld || lsu_wbck_vld || muldiv_wbck_vld)
                       && !rf_wen;

endmodule

// File: tb/tb_new_wbck_arb.sv
// Directed scoreboard bench for the write-back arbiter.
module tb_new_wbck_arb;

    typedef struct packed {
        logic        wen;
        logic [4:0]  idx;
        logic [31:0] dat;
        logic [1:0]  src;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_vld = 0, alu_rdy, alu_wen = 0;
    logic [4:0]  alu_idx = 0;
    logic [31:0] alu_dat = 0;
    logic        lsu_vld = 0, lsu_rdy, lsu_wen = 0;
    logic [4:0]  lsu_idx = 0;
    logic [31:0] lsu_dat = 0;
    logic        md_vld = 0, md_rdy, md_wen = 0;
    logic [4:0]  md_idx = 0;
    logic [31:0] md_dat = 0;
    logic        halt = 0;
    logic        rf_wen;
    logic [4:0]  rf_rdidx;
    logic [31:0] rf_wdat;
    logic [1:0]  grant_src;
    logic        wbck_idle;

    int total = 0;
    int bad = 0;
    exp_t q[$];
    logic [4:0]  last_idx = 0;
    logic [31:0] last_dat = 0;
    logic [1:0]  last_src = 0;

    always #5 clk = ~clk;

    new_wbck_arb dut (
        .clk               (clk),
        .rst               (rst),
        .alu_wbck_vld      (alu_vld),
        .alu_wbck_rdy      (alu_rdy),
        .alu_wbck_wen      (alu_wen),
        .alu_wbck_rdidx    (alu_idx),
        .alu_wbck_wdat     (alu_dat),
        .lsu_wbck_vld      (lsu_vld),
        .lsu_wbck_rdy      (lsu_rdy),
        .lsu_wbck_wen      (lsu_wen),
        .lsu_wbck_rdidx    (lsu_idx),
        .lsu_wbck_wdat     (lsu_dat),
        .muldiv_wbck_vld   (md_vld),
        .muldiv_wbck_rdy   (md_rdy),
        .muldiv_wbck_wen   (md_wen),
        .muldiv_wbck_rdidx (md_idx),
        .muldiv_wbck_wdat  (md_dat),
        .halt_req          (halt),
        .rf_wen            (rf_wen),
        .rf_rdidx          (rf_rdidx),
        .rf_wdat           (rf_wdat),
        .grant_src         (grant_src),
        .wbck_idle         (wbck_idle)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: check grant against exp_src, then check registered output.
    task automatic cyc(input string tag, input logic [1:0] exp_src);
        exp_t e;
        #1;
        chk({tag, ".alu_rdy"}, 32'(alu_rdy), 32'(exp_src == 2'd1));
        chk({tag, ".lsu_rdy"}, 32'(lsu_rdy), 32'(exp_src == 2'd2));
        chk({tag, ".md_rdy"},  32'(md_rdy),  32'(exp_src == 2'd3));
        e.wen = 1'b0;
        e.idx = last_idx;
        e.dat = last_dat;
        e.src = last_src;
        case (exp_src)
            2'd1: begin e.wen = alu_wen; e.idx = alu_idx; e.dat = alu_dat; end
            2'd2: begin e.wen = lsu_wen; e.idx = lsu_idx; e.dat = lsu_dat; end
            2'd3: begin e.wen = md_wen;  e.idx = md_idx;  e.dat = md_dat;  end
            default: ;
        endcase
        if (exp_src != 2'd0) begin
            e.wen = e.wen && (e.idx != 5'd0);
            e.src = exp_src;
        end
        last_idx = e.idx;
        last_dat = e.dat;
        last_src = e.src;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk({tag, ".rf_wen"},    32'(rf_wen),    32'(e.wen));
        chk({tag, ".rf_rdidx"},  32'(rf_rdidx),  32'(e.idx));
        chk({tag, ".rf_wdat"},   rf_wdat,        e.dat);
        chk({tag, ".grant_src"}, 32'(grant_src), 32'(e.src));
    endtask

    task automatic idle_all();
        alu_vld = 0;
        lsu_vld = 0;
        md_vld  = 0;
    endtask

    initial begin
        logic [1:0] seq [7];
        seq = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd3, 2'd2};

        // reset state
        #2;
        chk("rst.rf_wen", 32'(rf_wen), 32'd0);
        chk("rst.grant_src", 32'(grant_src), 32'd0);
        chk("rst.idle", 32'(wbck_idle), 32'd1);
        @(posedge clk);
        #1;
        rst = 0;

        // single ALU request
        alu_vld = 1; alu_wen = 1; alu_idx = 5'd5; alu_dat = 32'h12345678;
        cyc("single", 2'd1);
        idle_all();
        chk("single.idle_busy", 32'(wbck_idle), 32'd0);
        cyc("single_after", 2'd0);
        chk("single.idle", 32'(wbck_idle), 32'd1);

        // contention with starvation
        alu_vld = 1; alu_wen = 1; alu_idx = 5'd1; alu_dat = 32'hA1A1A1A1;
        lsu_vld = 1; lsu_wen = 1; lsu_idx = 5'd2; lsu_dat = 32'hB2B2B2B2;
        md_vld  = 1; md_wen  = 1; md_idx  = 5'd3; md_dat  = 32'hC3C3C3C3;
        for (int i = 0; i < 7; i++) begin
            cyc($sformatf("cont%0d", i), seq[i]);
            lsu_dat = lsu_dat + 32'd1;
        end
        idle_all();
        cyc("cont_drain", 2'd0);

        // halt blocks grants and holds counters
        alu_vld = 1; alu_wen = 1; alu_idx = 5'd9; alu_dat = 32'h0BADF00D;
        halt = 1;
        for (int i = 0; i < 3; i++) begin
            cyc($sformatf("halt%0d", i), 2'd0);
            chk("halt.alu_cnt", 32'(dut.u_alu_cnt.cnt), 32'd0);
        end
        halt = 0;
        cyc("halt_rel", 2'd1);
        chk("halt.alu_cnt_after", 32'(dut.u_alu_cnt.cnt), 32'd0);
        idle_all();
        cyc("halt_drain", 2'd0);

        // x0 write suppression and no-rd result
        lsu_vld = 1; lsu_wen = 1; lsu_idx = 5'd0; lsu_dat = 32'hFFFFFFFF;
        cyc("x0", 2'd2);
        lsu_vld = 0;
        alu_vld = 1; alu_wen = 0; alu_idx = 5'd7; alu_dat = 32'h00000077;
        cyc("nowen", 2'd1);
        idle_all();
        cyc("nowen_drain", 2'd0);

        // asynchronous reset right after a MULDIV transfer
        md_vld = 1; md_wen = 1; md_idx = 5'd12; md_dat = 32'hDEADBEEF;
        cyc("md", 2'd3);
        md_vld = 0;
        #2;
        rst = 1;
        #1;
        chk("arst.rf_wen", 32'(rf_wen), 32'd0);
        chk("arst.rf_rdidx", 32'(rf_rdidx), 32'd0);
        chk("arst.rf_wdat", rf_wdat, 32'd0);
        chk("arst.grant_src", 32'(grant_src), 32'd0);
        @(posedge clk);
        #1;
        rst = 0;
        q.delete();
        last_idx = 0;
        last_dat = 0;
        last_src = 0;
        chk("arst.md_cnt", 32'(dut.u_md_cnt.cnt), 32'd0);
        chk("arst.alu_cnt", 32'(dut.u_alu_cnt.cnt), 32'd0);
        chk("arst.lsu_cnt", 32'(dut.u_lsu_cnt.cnt), 32'd0);
        cyc("arst_quiet0", 2'd0);
        cyc("arst_quiet1", 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
